// File: rtl/dtw_pkg.sv
// dtw_pkg: shared constants, types and helpers for the DTW sample fetcher.
//   N       - sample width (memory data width)
//   ADDR_W  - memory address width
//   SAMPLE  - memory depth, i.e. the longest legal sequence
//   fetch_state_t - sequencer states
//   fetch_beat_t  - one (template, test) pair plus its index tags; the
//                   absdiff field exists only when FETCH_ABS_DIFF_EN is defined.
package dtw_pkg;

  localparam int N      = 32;
  localparam int ADDR_W = 8;
  localparam int SAMPLE = 256;

  localparam logic [ADDR_W:0] LEN_MAX = (ADDR_W+1)'(SAMPLE);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [N-1:0]      temp;
    logic [N-1:0]      test;
    logic [ADDR_W-1:0] i;
    logic [ADDR_W-1:0] j;
    logic              row_last;
    logic              last;
`ifdef FETCH_ABS_DIFF_EN
    logic [N-1:0]      absdiff;
`endif
  } fetch_beat_t;

  // Lengths beyond the memory depth are treated as a full-depth sequence.
  function automatic logic [ADDR_W:0] clamp_len(input logic [ADDR_W:0] len);
    if (len > LEN_MAX) begin
      return LEN_MAX;
    end else begin
      return len;
    end
  endfunction

`ifdef FETCH_ABS_DIFF_EN
  // |a - b| of two signed samples. The difference is formed one bit wider so
  // it is exact; the magnitude is then truncated to N bits (modulo 2^N).
  function automatic logic [N-1:0] abs_diff(input logic [N-1:0] a, input logic [N-1:0] b);
    logic [N:0] d;
    logic [N:0] m;
    d = {a[N-1], a} - {b[N-1], b};
    m = d[N] ? (~d + (N+1)'(1)) : d;
    return m[N-1:0];
  endfunction
`endif

endpackage

// File: rtl/fetch_skid_fifo.sv
// fetch_skid_fifo: 2-entry FIFO of fetch_beat_t used to absorb reads that are
// already in flight when the consumer stalls.
//   clk, rst_n - clock, asynchronous active-low reset (flushes the FIFO)
//   push, din  - write a beat (ignored when full unless popping in the same cycle)
//   pop        - remove the head beat (ignored when empty)
//   head       - oldest stored beat
//   count      - number of stored beats (0..2)
//   empty/full - count == 0 / count == 2
module fetch_skid_fifo
  import dtw_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        push,
  input  fetch_beat_t din,
  input  logic        pop,
  output fetch_beat_t head,
  output logic [1:0]  count,
  output logic        empty,
  output logic        full
);

  fetch_beat_t mem [2];
  logic        rd_ptr;
  logic        wr_ptr;
  logic        do_push;
  logic        do_pop;

  // Status flags, qualified push/pop and the head view.
  always_comb begin
    empty   = (count == 2'd0);
    full    = (count == 2'd2);
    do_pop  = pop & ~empty;
    do_push = push & (~full | do_pop);
    head    = mem[rd_ptr];
  end

  // Storage, pointers and occupancy; push and pop together leave count unchanged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem[0] <= '0;
      mem[1] <= '0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= ~wr_ptr;
      end
      if (do_pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/dtw_sample_fetcher.sv
// dtw_sample_fetcher: walks the DTW cost matrix row-major (template index i
// outer, test index j inner), drives both sample-memory read addresses and
// streams each (template, test) pair to the DTW core over valid/ready.
// Optional macro FETCH_ABS_DIFF_EN adds |temp - test| to every beat.
//   start, temp_len, test_len         - begin a pass (lengths sampled on start)
//   temp_mem_addr, test_mem_addr      - registered read addresses
//   temp_memory_out, test_memory_out  - read data, one cycle after the address
//   out_valid/out_ready               - output handshake
//   out_temp, out_test, out_i, out_j  - pair payload and matrix position
//   out_row_last, out_last, out_absdiff
//   busy                              - a pass is in progress
//   done                              - one-cycle pulse at the end of a pass
module dtw_sample_fetcher
  import dtw_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W:0]   temp_len,
  input  logic [ADDR_W:0]   test_len,
  output logic [ADDR_W-1:0] temp_mem_addr,
  output logic [ADDR_W-1:0] test_mem_addr,
  input  logic [N-1:0]      temp_memory_out,
  input  logic [N-1:0]      test_memory_out,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [N-1:0]      out_temp,
  output logic [N-1:0]      out_test,
  output logic [ADDR_W-1:0] out_i,
  output logic [ADDR_W-1:0] out_j,
  output logic              out_row_last,
  output logic              out_last,
  output logic [N-1:0]      out_absdiff,
  output logic              busy,
  output logic              done
);

  localparam logic [ADDR_W:0] LEN_ONE = (ADDR_W+1)'(1);

  fetch_state_t      state;
  logic [ADDR_W:0]   len_i;
  logic [ADDR_W:0]   len_j;
  logic              pending;
  logic [ADDR_W-1:0] pend_i;
  logic [ADDR_W-1:0] pend_j;
  logic              pend_row_last;
  logic              pend_last;

  fetch_beat_t       head;
  fetch_beat_t       cap_beat;
  logic [1:0]        fifo_count;
  logic              fifo_empty;
  logic              fifo_full;
  logic              pop;
  logic [2:0]        occupancy;
  logic              at_row_end;
  logic              at_last;
  logic              issue;

  // Issue decision: beats already stored plus the read in flight, minus the
  // one leaving this cycle, must leave room so no returning read is lost.
  always_comb begin
    pop        = ~fifo_empty & out_ready;
    occupancy  = {1'b0, fifo_count} + {2'b00, pending} - {2'b00, pop};
    at_row_end = ({1'b0, test_mem_addr} == (len_j - LEN_ONE));
    at_last    = at_row_end & ({1'b0, temp_mem_addr} == (len_i - LEN_ONE));
    if (state == RUN) begin
      issue = (occupancy < 3'd2) & ~(fifo_full & ~pop);
    end else begin
      issue = 1'b0;
    end
  end

  // Beat captured from the memories, tagged with the position it was read for.
  always_comb begin
    cap_beat          = '0;
    cap_beat.temp     = temp_memory_out;
    cap_beat.test     = test_memory_out;
    cap_beat.i        = pend_i;
    cap_beat.j        = pend_j;
    cap_beat.row_last = pend_row_last;
    cap_beat.last     = pend_last;
`ifdef FETCH_ABS_DIFF_EN
    cap_beat.absdiff  = abs_diff(temp_memory_out, test_memory_out);
`endif
  end

  fetch_skid_fifo u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (pending),
    .din   (cap_beat),
    .pop   (pop),
    .head  (head),
    .count (fifo_count),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  // Stream outputs come straight from the FIFO head registers.
  always_comb begin
    out_valid    = ~fifo_empty;
    out_temp     = head.temp;
    out_test     = head.test;
    out_i        = head.i;
    out_j        = head.j;
    out_row_last = head.row_last;
    out_last     = head.last;
`ifdef FETCH_ABS_DIFF_EN
    out_absdiff  = head.absdiff;
`else
    out_absdiff  = '0;
`endif
  end

  // Sequencer: pass control, address walk and in-flight read tagging.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      len_i         <= '0;
      len_j         <= '0;
      temp_mem_addr <= '0;
      test_mem_addr <= '0;
      pending       <= 1'b0;
      pend_i        <= '0;
      pend_j        <= '0;
      pend_row_last <= 1'b0;
      pend_last     <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
    end else begin
      done    <= 1'b0;
      pending <= issue;
      if (issue) begin
        pend_i        <= temp_mem_addr;
        pend_j        <= test_mem_addr;
        pend_row_last <= at_row_end;
        pend_last     <= at_last;
      end
      case (state)
        IDLE: begin
          if (start) begin
            if ((temp_len != '0) && (test_len != '0)) begin
              len_i         <= clamp_len(temp_len);
              len_j         <= clamp_len(test_len);
              temp_mem_addr <= '0;
              test_mem_addr <= '0;
              busy          <= 1'b1;
              state         <= RUN;
            end else begin
              done <= 1'b1;
            end
          end
        end
        RUN: begin
          if (issue) begin
            // The final read leaves both addresses parked on the last pair.
            if (at_last) begin
              state <= DRAIN;
            end else if (at_row_end) begin
              test_mem_addr <= '0;
              temp_mem_addr <= temp_mem_addr + 1'b1;
            end else begin
              test_mem_addr <= test_mem_addr + 1'b1;
            end
          end
        end
        DRAIN: begin
          if (pop && head.last) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dtw_sample_fetcher.sv
// Directed-plus-random bench for dtw_sample_fetcher. Expected beats come from
// a queue built by nested loops over the latched lengths and memory images.
module tb_dtw_sample_fetcher;
  import dtw_pkg::*;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic              out_ready = 1'b0;
  logic [ADDR_W:0]   temp_len = '0;
  logic [ADDR_W:0]   test_len = '0;
  logic [ADDR_W-1:0] temp_mem_addr, test_mem_addr, out_i, out_j;
  logic [N-1:0]      temp_memory_out, test_memory_out, out_temp, out_test, out_absdiff;
  logic              out_valid, out_row_last, out_last, busy, done;

  logic [N-1:0] temp_mem [SAMPLE];
  logic [N-1:0] test_mem [SAMPLE];

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [N-1:0] temp;
    logic [N-1:0] test;
    logic [N-1:0] absd;
    int           i;
    int           j;
    logic         row_last;
    logic         last;
  } exp_t;

  exp_t model_q[$];

  dtw_sample_fetcher dut (
    .clk(clk), .rst_n(rst_n), .start(start), .temp_len(temp_len), .test_len(test_len),
    .temp_mem_addr(temp_mem_addr), .test_mem_addr(test_mem_addr),
    .temp_memory_out(temp_memory_out), .test_memory_out(test_memory_out),
    .out_valid(out_valid), .out_ready(out_ready), .out_temp(out_temp), .out_test(out_test),
    .out_i(out_i), .out_j(out_j), .out_row_last(out_row_last), .out_last(out_last),
    .out_absdiff(out_absdiff), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Block RAM models with a one-cycle registered read.
  always @(posedge clk) begin
    temp_memory_out <= temp_mem[temp_mem_addr];
    test_memory_out <= test_mem[test_mem_addr];
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [N-1:0] ref_abs(input logic [N-1:0] a, input logic [N-1:0] b);
    longint d;
    d = longint'($signed(a)) - longint'($signed(b));
    if (d < 0) d = -d;
    return d[N-1:0];
  endfunction

  task automatic check_all_zero(input string tag);
    check({tag, ":valid"}, out_valid, 0);
    check({tag, ":busy"}, busy, 0);
    check({tag, ":done"}, done, 0);
    check({tag, ":taddr"}, temp_mem_addr, 0);
    check({tag, ":saddr"}, test_mem_addr, 0);
    check({tag, ":temp"}, out_temp, 0);
    check({tag, ":test"}, out_test, 0);
    check({tag, ":ij"}, {out_i, out_j}, 0);
    check({tag, ":flags"}, {out_row_last, out_last}, 0);
    check({tag, ":absdiff"}, out_absdiff, 0);
  endtask

  task automatic fill_random();
    for (int k = 0; k < SAMPLE; k++) begin
      temp_mem[k] = $urandom;
      test_mem[k] = $urandom;
    end
  endtask

  // Zero-length start: done at start+1, nothing streamed, addresses untouched.
  task automatic run_zero(input int tl, input int sl, input int ea, input int eb, input string name);
    @(negedge clk);
    temp_len = 9'(tl); test_len = 9'(sl); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check({name, ":done"}, done, 1);
    check({name, ":busy"}, busy, 0);
    check({name, ":valid"}, out_valid, 0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check({name, ":done_after"}, done, 0);
      check({name, ":valid_after"}, out_valid, 0);
      check({name, ":addr"}, {temp_mem_addr, test_mem_addr}, {8'(ea), 8'(eb)});
    end
  endtask

  // One full pass against the model; ready_pct sets the consumer acceptance
  // rate, stray_n (if >0) pulses start at that cycle of the pass.
  task automatic run_pass(input int tl, input int sl, input int ready_pct, input int stray_n, input string name);
    int et, es, n, budget, first_valid_n, last_n, done_n, done_cnt, max_addr;
    logic prev_stall;
    exp_t e;
    et = (tl > SAMPLE) ? SAMPLE : tl;
    es = (sl > SAMPLE) ? SAMPLE : sl;
    model_q.delete();
    for (int i = 0; i < et; i++) begin
      for (int j = 0; j < es; j++) begin
        e.temp = temp_mem[i];
        e.test = test_mem[j];
`ifdef FETCH_ABS_DIFF_EN
        e.absd = ref_abs(temp_mem[i], test_mem[j]);
`else
        e.absd = '0;
`endif
        e.i = i;
        e.j = j;
        e.row_last = (j == es - 1);
        e.last = (i == et - 1) && (j == es - 1);
        model_q.push_back(e);
      end
    end
    @(negedge clk);
    temp_len = 9'(tl); test_len = 9'(sl); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check({name, ":busy_on"}, busy, 1);
    n = 1; first_valid_n = -1; last_n = -1; done_n = -1; done_cnt = 0; max_addr = 0;
    prev_stall = 1'b0;
    budget = et * es * 4 + 40;
    while (n < budget && !(model_q.size() == 0 && done_n >= 0 && n > done_n + 2)) begin
      if (n == stray_n) begin
        start = 1'b1; temp_len = 9'd5; test_len = 9'd7;
      end else begin
        start = 1'b0;
      end
      out_ready = ($urandom_range(99) < ready_pct);
      if (int'(test_mem_addr) > max_addr) max_addr = int'(test_mem_addr);
      if (done) begin
        done_cnt++;
        if (done_n < 0) done_n = n;
      end
      if (prev_stall) check({name, ":hold_valid"}, out_valid, 1);
      if (out_valid) begin
        if (first_valid_n < 0) first_valid_n = n;
        if (model_q.size() == 0) begin
          check({name, ":extra_beat"}, out_valid, 0);
        end else begin
          e = model_q[0];
          check({name, ":temp"}, out_temp, e.temp);
          check({name, ":test"}, out_test, e.test);
          check({name, ":i"}, out_i, e.i);
          check({name, ":j"}, out_j, e.j);
          check({name, ":row_last"}, out_row_last, e.row_last);
          check({name, ":last"}, out_last, e.last);
          check({name, ":absdiff"}, out_absdiff, e.absd);
          if (out_ready) begin
            void'(model_q.pop_front());
            if (e.last) last_n = n;
          end
        end
      end
      prev_stall = out_valid && !out_ready;
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    check({name, ":beats_left"}, model_q.size(), 0);
    check({name, ":first_valid"}, first_valid_n, 3);
    check({name, ":done_count"}, done_cnt, 1);
    check({name, ":done_cycle"}, done_n, last_n + 1);
    check({name, ":addr_peak"}, max_addr, es - 1);
    check({name, ":busy_off"}, busy, 0);
    check({name, ":valid_off"}, out_valid, 0);
  endtask

  initial begin
    fill_random();
    // Reset state.
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);
    check_all_zero("post_reset");

    run_zero(0, 5, 0, 0, "zero_temp");
    run_zero(3, 0, 0, 0, "zero_test");

    run_pass(3, 2, 100, -1, "p3x2");
    run_pass(3, 2, 50, -1, "p3x2_rnd");
    run_zero(0, 0, 2, 1, "zero_both");

    // Signed magnitude cases: (5,-3)->8, (5,2)->3, (-7,-3)->4, (-7,2)->9.
    temp_mem[0] = 32'd5;
    temp_mem[1] = 32'hFFFF_FFF9;
    test_mem[0] = 32'hFFFF_FFFD;
    test_mem[1] = 32'd2;
    run_pass(2, 2, 100, -1, "absdiff");

    for (int k = 0; k < SAMPLE; k++) test_mem[k] = N'(k);
    run_pass(1, 256, 100, -1, "p1x256");

    fill_random();
    run_pass(6, 5, 60, 4, "stray_start");
    run_pass(2, 300, 100, -1, "clamp");

    // Abort mid-pass with the FIFO full, then a clean pass.
    @(negedge clk);
    temp_len = 9'd4; test_len = 9'd4; start = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    check("abort:valid_before", out_valid, 1);
    rst_n = 1'b0;
    #1;
    check_all_zero("abort");
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("abort:no_done", done, 0);
      check("abort:no_valid", out_valid, 0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    check("abort:done_release", done, 0);
    check("abort:busy_release", busy, 0);
    run_pass(3, 3, 70, -1, "after_abort");

    for (int r = 0; r < 3; r++) begin
      fill_random();
      run_pass($urandom_range(9, 1), $urandom_range(9, 1), 50, -1, "random");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
